// File: rtl/dac_spi_master.sv
// rtl/dac_spi_master.sv - 24-bit SPI master with SYNC framing and a one-deep request queue
//
// Ports:
//   clk             system clock
//   rst             asynchronous reset, active high
//   start           frame request, sampled every cycle
//   data_in[23:0]   command word, captured on the cycle start is accepted
//   busy            high from the cycle after acceptance until the SYNC gap ends
//   new_data        one-cycle pulse when a frame completes
//   data_out[23:0]  word received on miso, updated on the new_data cycle
//   overrun         sticky, set when a start request is dropped
//   sclk            SPI clock, idles high
//   mosi            serial data out, MSB first
//   miso            serial readback data
//   sync_n          frame select, active low
module dac_spi_master #(
    parameter int CLK_DIV  = 2,
    parameter int SYNC_GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] data_in,
    output logic        busy,
    output logic        new_data,
    output logic [23:0] data_out,
    output logic        overrun,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        sync_n
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LEN  = 8'(SYNC_GAP);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        TRAIL,
        DONE,
        GAP
    } state_t;

    state_t      state, state_d;
    logic [7:0]  div_cnt, div_cnt_d;
    logic        low_phase, low_phase_d;
    logic [4:0]  bit_cnt, bit_cnt_d;
    logic [7:0]  gap_cnt, gap_cnt_d;
    logic [23:0] tx_sreg, tx_sreg_d;
    logic [23:0] rx_sreg, rx_sreg_d;
    logic [23:0] pend_data, pend_data_d;
    logic        pend_valid, pend_valid_d;

    logic        busy_d, new_data_d, overrun_d, sclk_d, mosi_d, sync_n_d;
    logic [23:0] data_out_d;

    logic        launch;
    logic [23:0] launch_word;

    // Every output is a register loaded from its *_d value, so the pins
    // always describe the cycle the state register is currently in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            low_phase  <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            tx_sreg    <= '0;
            rx_sreg    <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            busy       <= 1'b0;
            new_data   <= 1'b0;
            data_out   <= '0;
            overrun    <= 1'b0;
            sclk       <= 1'b1;
            mosi       <= 1'b0;
            sync_n     <= 1'b1;
        end else begin
            state      <= state_d;
            div_cnt    <= div_cnt_d;
            low_phase  <= low_phase_d;
            bit_cnt    <= bit_cnt_d;
            gap_cnt    <= gap_cnt_d;
            tx_sreg    <= tx_sreg_d;
            rx_sreg    <= rx_sreg_d;
            pend_data  <= pend_data_d;
            pend_valid <= pend_valid_d;
            busy       <= busy_d;
            new_data   <= new_data_d;
            data_out   <= data_out_d;
            overrun    <= overrun_d;
            sclk       <= sclk_d;
            mosi       <= mosi_d;
            sync_n     <= sync_n_d;
        end
    end

    always_comb begin
        state_d      = state;
        div_cnt_d    = div_cnt;
        low_phase_d  = low_phase;
        bit_cnt_d    = bit_cnt;
        gap_cnt_d    = gap_cnt;
        tx_sreg_d    = tx_sreg;
        rx_sreg_d    = rx_sreg;
        pend_data_d  = pend_data;
        pend_valid_d = pend_valid;
        busy_d       = busy;
        new_data_d   = 1'b0;
        data_out_d   = data_out;
        overrun_d    = overrun;
        sclk_d       = sclk;
        mosi_d       = mosi;
        sync_n_d     = sync_n;
        launch       = 1'b0;
        launch_word  = data_in;

        case (state)
            IDLE: begin
                if (start) begin
                    launch      = 1'b1;
                    launch_word = data_in;
                end
            end

            SHIFT: begin
                if (start) overrun_d = 1'b1;
                div_cnt_d = div_cnt + 8'd1;
                if (div_cnt == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!low_phase) begin
                        low_phase_d = 1'b1;
                        sclk_d      = 1'b0;
                    end else begin
                        // Last cycle of the low phase: take the readback bit.
                        rx_sreg_d   = {rx_sreg[22:0], miso};
                        low_phase_d = 1'b0;
                        sclk_d      = 1'b1;
                        if (bit_cnt == 5'd0) begin
                            state_d = TRAIL;
                        end else begin
                            bit_cnt_d = bit_cnt - 5'd1;
                            tx_sreg_d = {tx_sreg[22:0], 1'b0};
                            mosi_d    = tx_sreg[22];
                        end
                    end
                end
            end

            TRAIL: begin
                if (start) overrun_d = 1'b1;
                div_cnt_d = div_cnt + 8'd1;
                if (div_cnt == DIV_LAST) begin
                    div_cnt_d  = '0;
                    state_d    = DONE;
                    sync_n_d   = 1'b1;
                    mosi_d     = 1'b0;
                    new_data_d = 1'b1;
                    data_out_d = rx_sreg;
                    gap_cnt_d  = 8'd1;
                end
            end

            DONE, GAP: begin
                // gap_cnt counts high SYNC cycles so far, the DONE cycle being 1.
                if (gap_cnt >= GAP_LEN) begin
                    if (pend_valid) begin
                        launch       = 1'b1;
                        launch_word  = pend_data;
                        pend_valid_d = 1'b0;
                        if (start) overrun_d = 1'b1;
                    end else if (start) begin
                        launch      = 1'b1;
                        launch_word = data_in;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    gap_cnt_d = gap_cnt + 8'd1;
                    state_d   = GAP;
                    if (start) begin
                        if (pend_valid) begin
                            overrun_d = 1'b1;
                        end else begin
                            pend_valid_d = 1'b1;
                            pend_data_d  = data_in;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d     = SHIFT;
            tx_sreg_d   = launch_word;
            bit_cnt_d   = 5'd23;
            div_cnt_d   = '0;
            low_phase_d = 1'b0;
            busy_d      = 1'b1;
            sync_n_d    = 1'b0;
            sclk_d      = 1'b1;
            mosi_d      = launch_word[23];
        end
    end

endmodule

// File: tb/tb_dac_spi_master.sv
// tb/tb_dac_spi_master.sv - randomized and directed self-checking bench for dac_spi_master
module tb_dac_spi_master;

    localparam int D      = 2;
    localparam int SG     = 2;
    localparam int N_SHIFT = 48 * D;
    localparam int N_TRAIL = 49 * D;
    localparam int N_DONE  = 49 * D + 1;
    localparam int N_END   = 49 * D + SG;

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] data_in;
    logic        busy;
    logic        new_data;
    logic [23:0] data_out;
    logic        overrun;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        sync_n;

    logic        loop;
    logic        miso_r;
    assign miso = loop ? mosi : miso_r;

    dac_spi_master #(.CLK_DIV(D), .SYNC_GAP(SG)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .busy     (busy),
        .new_data (new_data),
        .data_out (data_out),
        .overrun  (overrun),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .sync_n   (sync_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk24(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are driven at the falling edge; take a settled copy for the model.
    logic        s_start;
    logic [23:0] s_data;
    logic        s_miso;
    initial begin
        s_start = 1'b0;
        s_data  = '0;
        s_miso  = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            s_start = start;
            s_data  = data_in;
            s_miso  = miso;
        end
    end

    initial begin
        miso_r = 1'b0;
        forever begin
            @(negedge clk);
            miso_r = 1'($urandom_range(0, 1));
        end
    end

    // Reference model: a frame is an accepted word plus the cycle it was
    // accepted in; every output follows from the offset into that frame.
    bit          m_active;
    int          m_cyc;
    int          m_t0;
    int          m_n;
    logic [23:0] m_w;
    bit          m_pend;
    logic [23:0] m_pw;
    logic        m_ovr;
    logic [23:0] m_rx;
    logic [23:0] m_dout;

    initial begin
        m_active = 0; m_cyc = 0; m_t0 = 0; m_n = 0; m_w = '0;
        m_pend = 0; m_pw = '0; m_ovr = 1'b0; m_rx = '0; m_dout = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 0; m_pend = 0; m_ovr = 1'b0; m_dout = '0; m_cyc = 0;
            end else begin
                m_n = m_cyc - m_t0;
                if (!m_active) begin
                    if (s_start) begin
                        m_active = 1; m_t0 = m_cyc; m_w = s_data;
                    end
                end else if (m_n <= N_TRAIL) begin
                    if (s_start) m_ovr = 1'b1;
                    if (m_n <= N_SHIFT && (m_n % (2 * D)) == 0)
                        m_rx = {m_rx[22:0], s_miso};
                end else begin
                    if (m_n == N_END) begin
                        if (m_pend) begin
                            m_t0 = m_cyc; m_w = m_pw; m_pend = 0;
                            if (s_start) m_ovr = 1'b1;
                        end else if (s_start) begin
                            m_t0 = m_cyc; m_w = s_data;
                        end else begin
                            m_active = 0;
                        end
                    end else if (s_start) begin
                        if (m_pend) m_ovr = 1'b1;
                        else begin m_pend = 1; m_pw = s_data; end
                    end
                end
                m_cyc++;
                if (m_active && (m_cyc - m_t0) == N_DONE) m_dout = m_rx;
            end
        end
    end

    logic e_sync, e_sclk, e_mosi, e_busy, e_nd;
    int   e_n;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e_sync = 1'b1; e_sclk = 1'b1; e_mosi = 1'b0; e_busy = 1'b0; e_nd = 1'b0;
                if (m_active) begin
                    e_n    = m_cyc - m_t0;
                    e_busy = 1'b1;
                    if (e_n <= N_SHIFT) begin
                        e_sync = 1'b0;
                        e_sclk = (((e_n - 1) / D) % 2) == 0;
                        e_mosi = m_w[23 - (e_n - 1) / (2 * D)];
                    end else if (e_n <= N_TRAIL) begin
                        e_sync = 1'b0;
                        e_mosi = m_w[0];
                    end else if (e_n == N_DONE) begin
                        e_nd = 1'b1;
                    end
                end
                chk1("cyc_sync_n", sync_n, e_sync);
                chk1("cyc_sclk", sclk, e_sclk);
                chk1("cyc_mosi", mosi, e_mosi);
                chk1("cyc_busy", busy, e_busy);
                chk1("cyc_new_data", new_data, e_nd);
                chk1("cyc_overrun", overrun, m_ovr);
                chk24("cyc_data_out", data_out, m_dout);
            end
        end
    end

    // Per-cycle recording for the directed scenarios, cycle 0 = start cycle.
    logic        obs_sync [0:255];
    logic        obs_sclk [0:255];
    logic        obs_mosi [0:255];
    logic        obs_nd   [0:255];
    logic        obs_busy [0:255];
    logic        obs_ovr  [0:255];
    logic [23:0] obs_dout [0:255];

    task automatic rec(input int c);
        obs_sync[c] = sync_n;
        obs_sclk[c] = sclk;
        obs_mosi[c] = mosi;
        obs_nd[c]   = new_data;
        obs_busy[c] = busy;
        obs_ovr[c]  = overrun;
        obs_dout[c] = data_out;
    endtask

    task automatic observe(input logic [23:0] w1, input int at2, input logic [23:0] w2, input int ncyc);
        @(negedge clk);
        start   = 1'b1;
        data_in = w1;
        rec(0);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start   = 1'b0;
            data_in = 24'($urandom);
            if (c == at2) begin
                start   = 1'b1;
                data_in = w2;
            end
            rec(c);
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk1("wait_idle_bound", k < 500, 1'b1);
        @(negedge clk);
    endtask

    function automatic int cnt_sync_low(input int a, input int b);
        int k = 0;
        for (int c = a; c <= b; c++) if (obs_sync[c] == 1'b0) k++;
        return k;
    endfunction

    function automatic int first_sync_low(input int a, input int b);
        for (int c = a; c <= b; c++) if (obs_sync[c] == 1'b0) return c;
        return -1;
    endfunction

    function automatic int last_sync_low(input int a, input int b);
        int r = -1;
        for (int c = a; c <= b; c++) if (obs_sync[c] == 1'b0) r = c;
        return r;
    endfunction

    function automatic int cnt_nd(input int a, input int b);
        int k = 0;
        for (int c = a; c <= b; c++) if (obs_nd[c] == 1'b1) k++;
        return k;
    endfunction

    function automatic int cnt_falls(input int a, input int b);
        int k = 0;
        for (int c = (a < 1 ? 1 : a); c <= b; c++)
            if (obs_sclk[c-1] == 1'b1 && obs_sclk[c] == 1'b0) k++;
        return k;
    endfunction

    function automatic logic [23:0] fall_word(input int a, input int b);
        logic [23:0] w = '0;
        for (int c = (a < 1 ? 1 : a); c <= b; c++)
            if (obs_sclk[c-1] == 1'b1 && obs_sclk[c] == 1'b0) w = {w[22:0], obs_mosi[c]};
        return w;
    endfunction

    logic [23:0] w_rand;
    int          nd_seen;
    int          sync_lo_seen;
    int          p_tab [0:5] = '{1, 2, 8, 40, 150, 3};

    initial begin
        rst = 1'b1; start = 1'b0; data_in = '0; loop = 1'b0; chk_en = 1'b0;
        #12;
        chk1("rst_sync_n", sync_n, 1'b1);
        chk1("rst_sclk", sclk, 1'b1);
        chk1("rst_mosi", mosi, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_new_data", new_data, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        chk24("rst_data_out", data_out, 24'h0);
        repeat (3) begin
            @(negedge clk);
            start = 1'b1;
            chk1("rst_sclk_quiet", sclk, 1'b1);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame.
        observe(24'h280001, -1, 24'h0, 110);
        chki("f1_sync_first", first_sync_low(0, 110), 1);
        chki("f1_sync_last", last_sync_low(0, 110), 98);
        chki("f1_sync_count", cnt_sync_low(0, 110), 98);
        chki("f1_falls", cnt_falls(0, 110), 24);
        chk1("f1_sclk_c2", obs_sclk[2], 1'b1);
        chk1("f1_sclk_c3", obs_sclk[3], 1'b0);
        chk1("f1_sclk_c95", obs_sclk[95], 1'b0);
        chk1("f1_sclk_c97", obs_sclk[97], 1'b1);
        chk24("f1_word", fall_word(0, 110), 24'h280001);
        chki("f1_nd_count", cnt_nd(0, 110), 1);
        chk1("f1_nd_c99", obs_nd[99], 1'b1);
        chk1("f1_busy_c0", obs_busy[0], 1'b0);
        chk1("f1_busy_c1", obs_busy[1], 1'b1);
        chk1("f1_busy_c100", obs_busy[100], 1'b1);
        chk1("f1_busy_c101", obs_busy[101], 1'b0);
        wait_idle();

        // Back-to-back: second start one cycle after new_data.
        w_rand = 24'($urandom);
        observe(w_rand, 100, 24'h3F8000, 210);
        chk1("b2b_overrun", obs_ovr[210], 1'b0);
        chk1("b2b_sync_c98", obs_sync[98], 1'b0);
        chk1("b2b_sync_c99", obs_sync[99], 1'b1);
        chk1("b2b_sync_c100", obs_sync[100], 1'b1);
        chk1("b2b_sync_c101", obs_sync[101], 1'b0);
        chk24("b2b_word1", fall_word(0, 100), w_rand);
        chk24("b2b_word2", fall_word(101, 210), 24'h3F8000);
        chki("b2b_falls2", cnt_falls(101, 210), 24);
        chki("b2b_nd_count", cnt_nd(0, 210), 2);
        chk1("b2b_nd_c199", obs_nd[199], 1'b1);
        wait_idle();

        // Loopback.
        loop = 1'b1;
        observe(24'hA5C3F0, -1, 24'h0, 110);
        chk24("loop_dout_c99", obs_dout[99], 24'hA5C3F0);
        chk24("loop_dout_c110", obs_dout[110], 24'hA5C3F0);
        loop = 1'b0;
        wait_idle();

        // Overrun mid-shift.
        w_rand = 24'($urandom);
        observe(w_rand, 40, 24'hFFFFFF, 130);
        chk1("ovr_c40", obs_ovr[40], 1'b0);
        chk1("ovr_c41", obs_ovr[41], 1'b1);
        chk1("ovr_c130", obs_ovr[130], 1'b1);
        chk24("ovr_word", fall_word(0, 130), w_rand);
        chki("ovr_nd_count", cnt_nd(0, 130), 1);
        wait_idle();

        // Reset mid-frame, asserted between clock edges.
        @(negedge clk);
        start   = 1'b1;
        data_in = 24'($urandom);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        chk1("mrst_sync_n", sync_n, 1'b1);
        chk1("mrst_sclk", sclk, 1'b1);
        chk1("mrst_mosi", mosi, 1'b0);
        chk1("mrst_busy", busy, 1'b0);
        chk1("mrst_new_data", new_data, 1'b0);
        chk1("mrst_overrun", overrun, 1'b0);
        chk24("mrst_data_out", data_out, 24'h0);
        repeat (3) begin
            @(negedge clk);
            chk1("mrst_sclk_quiet", sclk, 1'b1);
        end
        @(negedge clk);
        rst = 1'b0;
        nd_seen = 0;
        sync_lo_seen = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (new_data) nd_seen++;
            if (!sync_n) sync_lo_seen++;
        end
        chki("mrst_no_nd", nd_seen, 0);
        chki("mrst_no_sync", sync_lo_seen, 0);
        w_rand = 24'($urandom);
        observe(w_rand, -1, 24'h0, 110);
        chk24("mrst_clean_word", fall_word(0, 110), w_rand);
        chk1("mrst_clean_nd", obs_nd[99], 1'b1);
        chki("mrst_clean_sync", cnt_sync_low(0, 110), 98);
        wait_idle();

        // Randomized traffic, from saturating to sparse request rates.
        for (int s = 0; s < 6; s++) begin
            loop = 1'($urandom_range(0, 1));
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                start   = ($urandom_range(0, p_tab[s] - 1) == 0);
                data_in = 24'($urandom);
            end
        end
        start = 1'b0;
        wait_idle();
        wait_idle();
        chk1("rand_overrun_seen", overrun, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_spi_master.md
Name: dac_spi_master

Overview:
- 24-bit SPI transmit/receive master for the quad DAC. It sits directly downstream of the channel-sequencer / message-ROM stage.
- The sequencer presents a 24-bit command word and pulses start. This block frames the word with SYNC, shifts it out MSB first, then returns a one-cycle new_data pulse. That pulse is what advances the sequencer to its next word.
- A back-to-back start, arriving one cycle after new_data, is queued rather than dropped, so the sequencer can chain words without gaps in its protocol.

Parameters:
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range 1 to 255.
- SYNC_GAP, 2, minimum clk cycles sync_n stays high between frames; legal range 1 to 255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- start  in  1  request a frame; sampled every cycle
- data_in  in  24  command word; captured on the cycle start is accepted
- busy  out  1  high from the cycle after an accepted start until the gap ends
- new_data  out  1  one-cycle pulse when a frame completes
- data_out  out  24  word shifted in on miso; updated on the new_data cycle, held otherwise
- overrun  out  1  sticky; set when a start is dropped
- sclk  out  1  SPI clock, idles high
- mosi  out  1  serial data, MSB first
- miso  in  1  serial readback data
- sync_n  out  1  frame select, active low

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - sync_n=1, sclk=1, mosi=0, busy=0, new_data=0, overrun=0, data_out=0.
  - Pending request cleared; FSM forced to IDLE.
- FSM states: IDLE, SHIFT, TRAIL, DONE, GAP.
- IDLE:
  - If start=1, latch data_in into the shift register, bit counter=23, go to SHIFT.
  - Call this acceptance cycle 0.
- SHIFT, starting at cycle 1:
  - sync_n=0, busy=1.
  - For each bit k=23..0: a high phase of CLK_DIV cycles (sclk=1, mosi=bit k), then a low phase of CLK_DIV cycles (sclk=0, mosi held).
  - The DAC samples mosi on the sclk falling edge.
  - miso is sampled into the receive shift register on the last clk cycle of each low phase.
  - After bit 0's low phase, go to TRAIL.
- TRAIL: sclk=1, sync_n=0 for CLK_DIV cycles, then go to DONE.
- DONE (one cycle, cycle 49*CLK_DIV+1):
  - sync_n=1, mosi=0, new_data=1, data_out=receive register.
  - Go to GAP.
- GAP:
  - sync_n stays high until SYNC_GAP cycles have elapsed, counted from the DONE cycle inclusive.
  - Then: if a request is pending, start the next frame (sync_n low on the next cycle); else go to IDLE with busy=0.
- Start during DONE or GAP:
  - Capture data_in into a one-deep pending register.
  - A second start while one is already pending: drop it and set overrun.
- Start during SHIFT or TRAIL: drop it, set overrun, current frame unaffected.
- Simultaneous start and the GAP-expiry cycle: the request is accepted into the pending register and launches immediately.
- overrun clears only on reset.
- Frame timing, CLK_DIV=2: sync_n low cycles 1..98, new_data on cycle 99, SCLK period 4 clk cycles, falling edges at cycles 3, 7, ..., 95.
- Counter widths:
  - Divider: 8 bits.
  - Bit counter: 5 bits, counts down 23..0, no wrap past 0.
  - Gap counter: 8 bits.

Test Plan:
- Reset: assert rst asynchronously between clock edges -> all outputs take their reset values immediately; no sclk activity while rst=1.
- Single frame, CLK_DIV=2, SYNC_GAP=2, start with data_in=24'h280001 at cycle 0 -> sync_n low exactly cycles 1..98; 24 falling edges; bits captured on falling edges = 24'h280001; new_data=1 only at cycle 99; busy low at cycle 101.
- Back-to-back: start with 24'h3F8000 one cycle after new_data -> no drop, overrun=0; sync_n high exactly 2 cycles; second frame transmits 24'h3F8000.
- Loopback, miso tied to mosi, data_in=24'hA5C3F0 -> data_out=24'hA5C3F0 on the new_data cycle, held afterwards.
- Overrun: start at cycle 40 mid-SHIFT with 24'hFFFFFF -> overrun=1 and stays high; frame still transmits the original word; only one new_data pulse.
- Reset mid-frame: rst at cycle 40 -> sync_n=1, sclk=1 without waiting for a clock edge; no new_data pulse; a start after release gives a clean full frame.
